// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants for the sequential divider
package div_pkg;
    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/AdderAndSubtractor_32bit.sv
// rtl/AdderAndSubtractor_32bit.sv - ripple add/subtract, Cin=1 selects A-B
module AdderAndSubtractor_32bit #(
    parameter int W = 32
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    output logic [W-1:0] S,
    output logic         Cout
);
    logic [W-1:0] b_eff;

    assign b_eff     = B ^ {W{Cin}};
    assign {Cout, S} = {1'b0, A} + {1'b0, b_eff} + {{W{1'b0}}, Cin};
endmodule

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH-1:0] diff;
    logic             cout;
    logic             no_borrow;

    assign rem_sh = {rem[WIDTH-2:0], quo[WIDTH-1]};

    AdderAndSubtractor_32bit #(.W(WIDTH)) u_sub (
        .A    (rem_sh),
        .B    (divisor),
        .Cin  (1'b1),
        .S    (diff),
        .Cout (cout)
    );

    // A set bit shifted out of rem makes the shifted value exceed any divisor,
    // so it counts as no-borrow; the low WIDTH bits of diff are then exact.
    assign no_borrow = rem[WIDTH-1] | cout;
    assign rem_next  = no_borrow ? diff : rem_sh;
    assign quo_next  = {quo[WIDTH-2:0], no_borrow};
endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle unsigned divider with start/busy/done handshake
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic               div_zero,
    output logic [2*WIDTH-1:0] Out
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (div_r),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            counter  <= '0;
            quo_r    <= '0;
            rem_r    <= '0;
            div_r    <= '0;
            div_zero <= 1'b0;
            Out      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        quo_r   <= A;
                        div_r   <= B;
                        rem_r   <= '0;
                        counter <= '0;
                        if (B == '0) begin
                            state    <= S_DONE;
                            div_zero <= 1'b1;
                            Out      <= {A, {WIDTH{1'b1}}};
                        end else begin
                            state    <= S_RUN;
                            div_zero <= 1'b0;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    rem_r   <= rem_next;
                    quo_r   <= quo_next;
                    counter <= counter + CNT_W'(1);
                    if (counter == LAST) begin
                        state <= S_DONE;
                        Out   <= {rem_next, quo_next};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed and random self-checking bench for div_sequencer
module tb_div_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [63:0] Out;

    int errors = 0;
    int checks = 0;

    div_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .Out      (Out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one op, optionally injecting a 9/2 start pulse at wait cycle inj.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_out, input int inj);
        int n;
        int busy_cnt;
        logic dz_exp;
        dz_exp = (b == 32'd0);
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) busy_cnt++;
            if (inj != 0 && n == inj) begin
                A = 32'd9; B = 32'd2; start = 1'b1;
            end
            if (inj != 0 && n == inj + 1) start = 1'b0;
        end while (!done && n < 40);
        chk({tag, "_latency"}, 64'(n), dz_exp ? 64'd1 : 64'd33);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), dz_exp ? 64'd0 : 64'd32);
        chk({tag, "_out"}, Out, exp_out);
        chk({tag, "_div_zero"}, 64'(div_zero), 64'(dz_exp));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, "_out_held"}, Out, exp_out);
    endtask

    initial begin
        int n;
        int done_cnt;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] rexp;

        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_div_zero", 64'(div_zero), 64'd0);
        chk("reset_out", Out, 64'd0);

        run_op("t1_100_7", 32'd100, 32'd7, {32'd2, 32'd14}, 0);
        run_op("t2_max_1", 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 0);
        run_op("t2_3_10", 32'd3, 32'd10, {32'd3, 32'd0}, 0);
        run_op("t3_div0", 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 0);
        run_op("t4_ignore", 32'd100, 32'd7, {32'd2, 32'd14}, 10);

        // Reset during RUN
        @(negedge clk);
        A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        chk("t5_busy_before_reset", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t5_reset_busy", 64'(busy), 64'd0);
        chk("t5_reset_done", 64'(done), 64'd0);
        chk("t5_reset_div_zero", 64'(div_zero), 64'd0);
        chk("t5_reset_out", Out, 64'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("t5_no_done_after_reset", 64'(done_cnt), 64'd0);
        run_op("t5_50_5", 32'd50, 32'd5, {32'd0, 32'd10}, 0);

        // Back-to-back with start held high across done
        @(negedge clk);
        A = 32'd20; B = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 A = 32'd40; B = 32'd6;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        chk("t6_first_latency", 64'(n), 64'd33);
        chk("t6_first_out", Out, {32'd2, 32'd6});
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        done_cnt = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("t6_second_accepted", 64'(busy), 64'd1);
            if (done) done_cnt++;
        end while (!done && n < 40);
        chk("t6_second_latency", 64'(n), 64'd33);
        chk("t6_second_out", Out, {32'd4, 32'd6});
        repeat (5) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("t6_done_pulses", 64'(done_cnt), 64'd1);

        // Random operands checked against the language's own / and %
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(1, 255));
                1:       rb = $urandom >> $urandom_range(0, 31);
                2:       rb = (i % 50 == 0) ? 32'd0 : $urandom;
                default: rb = $urandom;
            endcase
            rexp = (rb == 32'd0) ? {ra, 32'hFFFF_FFFF} : {ra % rb, ra / rb};
            run_op($sformatf("rand%0d", i), ra, rb, rexp, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
